// File: rtl/out_mem_dump_streamer_pkg.sv
// rtl/out_mem_dump_streamer_pkg.sv - shared state type and constants for the output memory dump streamer
package out_mem_dump_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPT,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    localparam int OUT_BASE  = 90302;
    localparam int PIX_COUNT = 90000;
    localparam int PIX_W     = 24;

endpackage

// File: rtl/out_mem_dump_streamer_byte_serializer.sv
// rtl/out_mem_dump_streamer_byte_serializer.sv - 24-bit to 3-byte MSB-first valid/ready shifter
module out_mem_dump_streamer_byte_serializer
    import out_mem_dump_streamer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PIX_W-1:0] load_data,
    input  logic             tready,
    output logic [7:0]       tdata,
    output logic             tvalid,
    output logic             tlast,
    output logic             fire
);

    logic [PIX_W-1:0] shreg_q, shreg_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic             valid_q, valid_d;

    always_comb begin
        shreg_d    = shreg_q;
        byte_idx_d = byte_idx_q;
        valid_d    = valid_q;
        fire       = valid_q & tready;
        if (load) begin
            shreg_d    = load_data;
            byte_idx_d = 2'd0;
            valid_d    = 1'b1;
        end else if (fire) begin
            shreg_d    = {shreg_q[PIX_W-9:0], 8'h00};
            byte_idx_d = byte_idx_q + 2'd1;
            // Valid drops together with the third handshake so no byte is ever retracted.
            if (byte_idx_q == 2'd2) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q    <= '0;
            byte_idx_q <= 2'd0;
            valid_q    <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
            valid_q    <= valid_d;
        end
    end

    assign tdata  = shreg_q[PIX_W-1:PIX_W-8];
    assign tvalid = valid_q;
    assign tlast  = (byte_idx_q == 2'd2);

endmodule

// File: rtl/out_mem_dump_streamer.sv
// rtl/out_mem_dump_streamer.sv - walks the output pixel window and streams each pixel as three bytes
module out_mem_dump_streamer
    import out_mem_dump_streamer_pkg::*;
#(
    parameter int WIDTH  = PIX_W,
    parameter int ADDR_W = 24,
    parameter int BASE   = OUT_BASE,
    parameter int COUNT  = PIX_COUNT,
    parameter int CNT_W  = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [WIDTH-1:0]  mem_rd,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_cnt
);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              load;
    logic              fire;
    logic              last;

    out_mem_dump_streamer_byte_serializer u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(mem_rd),
        .tready   (m_ready),
        .tdata    (m_data),
        .tvalid   (m_valid),
        .tlast    (last),
        .fire     (fire)
    );

    always_comb begin
        state_d    = state_q;
        mem_a_d    = mem_a_q;
        word_cnt_d = word_cnt_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mem_a_d    = ADDR_W'(BASE);
                    word_cnt_d = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_CAPT;
            ST_CAPT: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (fire && last) begin
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    // The address only advances when another pixel remains, so it stops at the last one.
                    if (word_cnt_q + CNT_W'(1) == CNT_W'(COUNT)) begin
                        state_d = ST_DONE;
                    end else begin
                        mem_a_d = mem_a_q + ADDR_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_a_q    <= ADDR_W'(BASE);
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_a_q    <= mem_a_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign word_cnt = word_cnt_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule
